// File: rtl/divider32_pkg.sv
// ============================================================================
// divider32_pkg : shared state encodings and constants for divider32_seq
// Revision      : 1.0
// ============================================================================
`default_nettype none

package divider32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [4:0]  C_ITER_COUNT   = 5'd31;
    localparam logic [31:0] C_DBZ_QUOTIENT = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/divider32_step.sv
// ============================================================================
// divider32_step : one restoring shift-and-subtract step of the divider
// Revision       : 1.0
// ============================================================================
`default_nettype none

module divider32_step (
    input  logic [32:0] r_i,
    input  logic [31:0] q_i,
    input  logic [31:0] d_i,
    output logic [32:0] r_o,
    output logic [31:0] q_o
);

    logic [32:0] w_s;
    logic [32:0] w_t;
    logic        unused_r_msb;

    // The partial remainder is always below D, so its top bit is structurally zero.
    assign unused_r_msb = r_i[32];

    always_comb begin
        w_s = {r_i[31:0], q_i[31]};
        w_t = w_s - {1'b0, d_i};
        if (!w_t[32]) begin
            r_o = w_t;
            q_o = {q_i[30:0], 1'b1};
        end else begin
            r_o = w_s;
            q_o = {q_i[30:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/divider32_seq.sv
// ============================================================================
// divider32_seq : multi-cycle unsigned 32-bit restoring divider with
//                 start/busy/done handshake and registered results
// Revision      : 1.0
// ============================================================================
`default_nettype none

module divider32_seq
    import divider32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    state_e           state_q;
    logic [4:0]       count_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;

    divider32_step u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_d),
        .q_o (q_d)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // DONE accepts a new request exactly like IDLE, allowing back-to-back use.
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (start_i) begin
                        if (divisor_i != '0) begin
                            d_q     <= divisor_i;
                            q_q     <= dividend_i;
                            r_q     <= '0;
                            count_q <= C_ITER_COUNT;
                            busy_q  <= 1'b1;
                            state_q <= ST_RUN;
                        end else begin
                            quot_q  <= C_DBZ_QUOTIENT;
                            rem_q   <= dividend_i;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    r_q     <= r_d;
                    q_q     <= q_d;
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd0) begin
                        quot_q  <= q_d;
                        rem_q   <= r_d[WIDTH-1:0];
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        count_q <= 5'd0;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_divider32_seq.sv
// ============================================================================
// tb_divider32_seq : self-checking bench for divider32_seq
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_divider32_seq;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_by_zero_o;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];

    divider32_seq #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        if (b == 32'd0) begin
            v.q = 32'hFFFF_FFFF;
            v.r = a;
            v.z = 1'b1;
        end else begin
            v.q = a / b;
            v.r = a % b;
            v.z = 1'b0;
        end
        return v;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        sb.push_back(model(a, b));
        tick();
        start_i    = 1'b0;
    endtask

    // Waits for done_o, checking handshake timing and output stability, then
    // scores the result against the oldest queued expectation.
    task automatic wait_check(input string tag, input int exp_lat, input int pulse_at);
        int          n = 0;
        logic        busy_gap = 1'b0;
        logic        moved = 1'b0;
        logic [31:0] q0 = quotient_o;
        logic [31:0] r0 = remainder_o;
        vec_t        e;
        while (!done_o && n < 40) begin
            if (!busy_o) busy_gap = 1'b1;
            if (quotient_o !== q0 || remainder_o !== r0) moved = 1'b1;
            start_i = (n == pulse_at);
            if (n == pulse_at) begin
                dividend_i = 32'hFFFF_FFFF;
                divisor_i  = 32'd0;
            end
            tick();
            n++;
        end
        start_i = 1'b0;
        if (!done_o) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (exp_lat >= 0) check({tag, " latency"}, n, exp_lat);
        check({tag, " busy_at_done"}, {31'd0, busy_o}, 32'd0);
        if (n > 0) check({tag, " busy_gap"}, {31'd0, busy_gap}, 32'd0);
        check({tag, " hold"}, {31'd0, moved}, 32'd0);
        if (sb.size() == 0) begin
            check({tag, " unexpected_done"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, " quotient"}, quotient_o, e.q);
        check({tag, " remainder"}, remainder_o, e.r);
        check({tag, " div_by_zero"}, {31'd0, div_by_zero_o}, {31'd0, e.z});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;

        tbl[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0};
        tbl[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b0};
        tbl[2] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3,          z: 1'b0};
        tbl[3] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5,          z: 1'b1};
        tbl[4] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          z: 1'b0};
        tbl[5] = '{a: 32'd7,          b: 32'd7,          q: 32'd1,          r: 32'd0,          z: 1'b0};
        tbl[6] = '{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'h8000_0000,  z: 1'b0};
        tbl[7] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          z: 1'b0};
        tbl[8] = '{a: 32'hFFFF_FFFF,  b: 32'h0001_0000,  q: 32'h0000_FFFF,  r: 32'h0000_FFFF,  z: 1'b0};
        tbl[9] = '{a: 32'd0,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b1};

        rst_n_i    = 1'b0;
        start_i    = 1'b0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        tick();
        tick();
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset quotient", quotient_o, 32'd0);
        check("reset remainder", remainder_o, 32'd0);
        check("reset dbz", {31'd0, div_by_zero_o}, 32'd0);
        rst_n_i = 1'b1;
        tick();

        // Table vectors: expectations come from the table, not the model.
        for (int i = 0; i < 10; i++) begin
            dividend_i = tbl[i].a;
            divisor_i  = tbl[i].b;
            start_i    = 1'b1;
            sb.push_back(tbl[i]);
            tick();
            start_i = 1'b0;
            if (tbl[i].z) check($sformatf("vec%0d busy_after_start", i), {31'd0, busy_o}, 32'd0);
            else          check($sformatf("vec%0d busy_after_start", i), {31'd0, busy_o}, 32'd1);
            wait_check($sformatf("vec%0d", i), tbl[i].z ? 0 : 32, -1);
            tick();
            check($sformatf("vec%0d done_pulse", i), {31'd0, done_o}, 32'd0);
        end

        // Back-to-back with a mid-RUN start pulse in both operations.
        start_op(32'd1000, 32'd3);
        wait_check("b2b_first", 32, 5);
        start_op(32'd81, 32'd9);
        check("b2b busy_no_gap", {31'd0, busy_o}, 32'd1);
        check("b2b done_dropped", {31'd0, done_o}, 32'd0);
        wait_check("b2b_second", 32, 12);
        tick();

        // Asynchronous reset in the middle of RUN discards the operation.
        start_op(32'hDEAD_BEEF, 32'h0000_1234);
        for (int i = 0; i < 9; i++) tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        check("midrst busy", {31'd0, busy_o}, 32'd0);
        check("midrst done", {31'd0, done_o}, 32'd0);
        check("midrst quotient", quotient_o, 32'd0);
        check("midrst remainder", remainder_o, 32'd0);
        check("midrst dbz", {31'd0, div_by_zero_o}, 32'd0);
        void'(sb.pop_back());
        tick();
        tick();
        check("midrst no_done", {31'd0, done_o}, 32'd0);
        rst_n_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o) break;
        end
        check("midrst stays_idle", {31'd0, done_o | busy_o}, 32'd0);
        start_op(32'hDEAD_BEEF, 32'h0000_1234);
        wait_check("post_reset", 32, -1);
        tick();

        // Random regression with biased operand classes.
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 4))
                0: begin a = $urandom; b = 32'd1; end
                1: begin a = $urandom_range(0, 1000); b = a + 32'd1 + $urandom_range(0, 100000); end
                2: begin a = 32'd0; b = $urandom; end
                3: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            start_op(a, b);
            wait_check($sformatf("rand%0d a=%h b=%h", i, a, b), (b == 32'd0) ? 0 : 32, -1);
            if ($urandom_range(0, 1) == 0) tick();
        end

        check("scoreboard empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
